gray_gen: RTL and testbench
===========================

// Module: gray_gen
// PURPOSE
//  Upstream feeder of the pipeline control FSM. While the FSM drives gray_en, it takes one frame of
//  24-bit RGB pixels in raster order and converts each pixel to 8-bit luma.
//  Each luma value is written to the gray frame buffer that the Sobel stage reads later.
//  gen_done reports a complete frame back to the FSM.
// PARAMETERS
//  IMG_W   320  pixels per line
//  IMG_H   240  lines per frame
//  ADDR_W  17   gray buffer address width; 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  gray_en    in   1       frame enable from the control FSM (level)
//  rgb_valid  in   1       input pixel valid
//  rgb_ready  out  1       input pixel ready; a beat transfers when valid & ready
//  rgb_data   in   24      {R[23:16],G[15:8],B[7:0]}
//  wr_en      out  1       gray buffer write strobe, one cycle per pixel
//  wr_addr    out  ADDR_W  gray buffer address, linear raster index
//  wr_data    out  8       luma
//  gen_done   out  1       frame complete (level)
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; pixel counter=0; pipeline valids=0;
//   rgb_ready, wr_en and gen_done = 0; wr_addr and wr_data = 0.
//  FSM states: IDLE, RUN, FLUSH, DONE.
//   IDLE : gray_en=1 -> RUN (counter=0).
//   RUN  : rgb_ready=1. Each accepted beat increments the counter.
//          Accepting beat IMG_W*IMG_H-1 -> FLUSH; that beat is the last one taken.
//   FLUSH: rgb_ready=0. When both pipeline stages are empty -> DONE.
//   DONE : gen_done=1, rgb_ready=0. gray_en=0 -> IDLE, and gen_done falls in the same transition.
//  Abort: gray_en=0 in RUN or FLUSH -> IDLE next cycle.
//   Pipeline valids are cleared, so no further wr_en; the counter is cleared; gen_done stays 0.
//  Arithmetic: sum = 77*R + 150*G + 29*B, unsigned 16 bit (max 65280, no overflow).
//   wr_data = sum[15:8].
//  Pipeline: stage 1 registers the three products; stage 2 registers the sum, the shift and the address.
//   wr_en is asserted exactly 2 cycles after the accepting edge.
//   Throughput is 1 pixel per cycle.
//  wr_addr = counter value at acceptance (0 .. IMG_W*IMG_H-1), contiguous regardless of rgb_valid gaps.
//  rgb_valid high outside RUN is ignored; no beat transfers.
//  The counter never wraps: the RUN exit on the last beat guarantees this.
//  gen_done rises the cycle after the final wr_en.
//  A new frame requires gray_en 1 -> 0 -> 1.
// CONFIGURATION
//  GRAY_ROUND_EN defined:   sum = 77*R + 150*G + 29*B + 128 (max 65408), giving round-to-nearest luma.
//  GRAY_ROUND_EN undefined: no bias; the shift truncates.
//  Ports, latency and FSM are identical in both builds.
// TESTING (IMG_W=4, IMG_H=2, ADDR_W=3 unless noted)
//  1. Reset mid-frame, after 3 accepted beats -> all outputs 0 immediately.
//     After release and gray_en=1, the next frame starts at wr_addr=0.
//  2. Colour values, checked in both builds:
//     0xFFFFFF -> 255. 0xFF0000 -> 76 (77 with GRAY_ROUND_EN).
//     0x00FF00 -> 149 (149). 0x0000FF -> 28 (29). 0x000000 -> 0.
//  3. 8 back-to-back beats -> wr_addr 0..7 on consecutive cycles, each 2 cycles after its accept.
//     gen_done=1 the cycle after wr_addr=7. rgb_ready=0 from the cycle after the 8th accept.
//  4. rgb_valid toggled randomly -> wr_addr still 0..7 with no gaps or duplicates, matching a reference model.
//  5. gray_en dropped after 3 accepts -> at most the in-flight writes (addr<=2) appear, then nothing;
//     gen_done never rises. Re-enable -> full frame from addr 0.
//  6. gray_en dropped while in DONE -> gen_done falls next cycle.
//     A beat offered in DONE is not accepted.

Source files
------------

// File: rtl/gray_gen.sv
// gray_gen: converts one raster frame of 24-bit RGB pixels to 8-bit luma writes for the gray frame buffer.
// Ports: clk; rst (async, active-low); gray_en (frame enable level); rgb_valid/rgb_ready/rgb_data
// ({R,G,B} input stream); wr_en/wr_addr/wr_data (gray buffer write port); gen_done (frame complete level).
// Optional GRAY_ROUND_EN adds a +128 bias before the >>8 so luma rounds to nearest instead of truncating.
module gray_gen #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gray_en,
  input  logic              rgb_valid,
  output logic              rgb_ready,
  input  logic [23:0]       rgb_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              gen_done
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
`ifdef GRAY_ROUND_EN
  localparam logic [15:0] BIAS = 16'd128;
`else
  localparam logic [15:0] BIAS = 16'd0;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, a1_q, a1_d, wr_addr_q, wr_addr_d;
  logic [15:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic v1_q, v1_d, wr_en_q, wr_en_d, acc, abort;
  assign rgb_ready = state_q == RUN;
  assign gen_done  = state_q == DONE;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  always_comb begin
    acc   = rgb_ready && rgb_valid;
    abort = !gray_en && (state_q == RUN || state_q == FLUSH);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (gray_en) begin
               state_d = RUN;
               cnt_d   = '0;
             end
      RUN:   if (acc) begin
               cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
               state_d = cnt_q == LAST ? FLUSH : RUN;
             end
      // stage 2 drains on this edge once stage 1 is empty, so gen_done follows the final write
      FLUSH: if (!v1_q) state_d = DONE;
      DONE:  if (!gray_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    v1_d = acc && !abort;
    a1_d = acc ? cnt_q : a1_q;
    pr_d = acc ? 16'(rgb_data[23:16]) * 16'd77  : pr_q;
    pg_d = acc ? 16'(rgb_data[15:8])  * 16'd150 : pg_q;
    pb_d = acc ? 16'(rgb_data[7:0])   * 16'd29  : pb_q;
    wr_en_d   = v1_q && !abort;
    wr_addr_d = v1_q ? a1_q : wr_addr_q;
    wr_data_d = v1_q ? 8'((pr_q + pg_q + pb_q + BIAS) >> 8) : wr_data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a1_q      <= '0;
      v1_q      <= 1'b0;
      pr_q      <= '0;
      pg_q      <= '0;
      pb_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a1_q      <= a1_d;
      v1_q      <= v1_d;
      pr_q      <= pr_d;
      pg_q      <= pg_d;
      pb_q      <= pb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_gray_gen.sv
// tb_gray_gen: directed, table-driven bench for gray_gen on a 4x2 frame.
module tb_gray_gen;
  logic clk = 0, rst = 0, gray_en = 0, rgb_valid = 0;
  logic [23:0] rgb_data = '0;
  logic rgb_ready, wr_en, gen_done;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0;
  typedef struct {
    logic [23:0] rgb;
    int y_t;
    int y_r;
  } vec_t;
  vec_t vec [8];
  gray_gen #(.IMG_W(4), .IMG_H(2), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .gray_en(gray_en), .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .rgb_data(rgb_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .gen_done(gen_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int luma(input int i);
`ifdef GRAY_ROUND_EN
    return vec[i].y_r;
`else
    return vec[i].y_t;
`endif
  endfunction
  task automatic frame(input bit rnd, input int stop_at);
    int n = 0, a1 = 0, a2 = 0, post = 0;
    bit p1 = 0, p2 = 0, done_nxt = 0, ab = 0, fin = 0, v;
    gray_en = 1;
    tick();
    chk("run_ready", int'(rgb_ready), 1);
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      if (n == stop_at && !ab) begin
        gray_en = 0;
        ab = 1;
      end
      v = !ab && n < 8 && (!rnd || $urandom_range(1, 0) == 1);
      rgb_valid = v;
      rgb_data = vec[n % 8].rgb;
      tick();
      p2 = ab ? 1'b0 : p1;
      a2 = a1;
      p1 = v;
      a1 = n;
      if (v) n++;
      chk("wr_en", int'(wr_en), int'(p2));
      if (p2) begin
        chk("wr_addr", int'(wr_addr), a2);
        chk("wr_data", int'(wr_data), luma(a2));
      end
      chk("gen_done", int'(gen_done), int'(done_nxt));
      chk("rgb_ready", int'(rgb_ready), int'(!ab && n < 8));
      if (done_nxt) fin = 1;
      done_nxt = p2 && a2 == 7;
      if (ab) post++;
      if (post > 4) fin = 1;
    end
    rgb_valid = 0;
    if (!fin) chk("frame_timeout", 0, 1);
  endtask
  task automatic done_tail();
    rgb_valid = 1;
    rgb_data = 24'hFFFFFF;
    tick();
    chk("done_ready", int'(rgb_ready), 0);
    chk("done_hold", int'(gen_done), 1);
    rgb_valid = 0;
    tick();
    chk("done_no_wr", int'(wr_en), 0);
    tick();
    chk("done_no_wr2", int'(wr_en), 0);
    gray_en = 0;
    tick();
    chk("done_fall", int'(gen_done), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{24'hFFFFFF, 255, 255};
    vec[1] = '{24'hFF0000, 76, 77};
    vec[2] = '{24'h00FF00, 149, 149};
    vec[3] = '{24'h0000FF, 28, 29};
    vec[4] = '{24'h000000, 0, 0};
    vec[5] = '{24'h808080, 128, 128};
    vec[6] = '{24'h123456, 45, 46};
    vec[7] = '{24'h0A0B0C, 10, 11};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(rgb_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_done", int'(gen_done), 0);
    rst = 1;
    rgb_valid = 1;
    rgb_data = 24'hFFFFFF;
    tick();
    tick();
    chk("idle_ready", int'(rgb_ready), 0);
    chk("idle_wr_en", int'(wr_en), 0);
    rgb_valid = 0;
    frame(0, 99);
    done_tail();
    frame(1, 99);
    done_tail();
    frame(1, 99);
    done_tail();
    frame(0, 3);
    chk("abort_done", int'(gen_done), 0);
    frame(0, 99);
    done_tail();
    gray_en = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rgb_valid = 1;
      rgb_data = vec[i + 5].rgb;
      tick();
    end
    chk("pre_rst_wr_en", int'(wr_en), 1);
    #2 rst = 0;
    #1;
    chk("mid_rst_ready", int'(rgb_ready), 0);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_addr", int'(wr_addr), 0);
    chk("mid_rst_data", int'(wr_data), 0);
    chk("mid_rst_done", int'(gen_done), 0);
    rgb_valid = 0;
    gray_en = 0;
    #2 rst = 1;
    tick();
    frame(0, 99);
    done_tail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
